// File: rtl/prog_mem_loader.sv
// 16x8 flop program memory with a byte-stream loader that holds the CPU in reset while loading.
// Optional macro PMEM_DEFAULT_PROG_EN presets a small demo program on reset instead of all zeros.
module prog_mem_loader #(
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] adr,
  output logic [7:0] dout,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       cpu_run,
  output logic       load_err,
  output logic       load_busy
);

  typedef enum logic {RUN, LOAD} state_t;

`ifdef PMEM_DEFAULT_PROG_EN
  // MVI 1; MOV r6,r0; LROTATE r0; JMP 1
  localparam logic [7:0] RESET_IMAGE [16] = '{8'hA1, 8'h30, 8'h78, 8'h91, default: 8'h00};
`else
  localparam logic [7:0] RESET_IMAGE [16] = '{default: 8'h00};
`endif

  state_t      state_q;
  logic [7:0]  mem_q [16];
  logic [3:0]  wptr_q;
  logic [23:0] idle_q;
  logic [23:0] idle_d;
  logic        cpu_run_q;
  logic        load_ready_q;
  logic        load_busy_q;
  logic        load_err_q;
  logic        wr_en;

  // A restart pulse wins over a byte presented in the same cycle.
  assign wr_en  = (state_q == LOAD) && load_valid && load_ready_q && !load_start;
  assign idle_d = (idle_q == 24'hFF_FFFF) ? idle_q : idle_q + 24'd1;
  assign dout   = mem_q[adr];

  assign cpu_run    = cpu_run_q;
  assign load_ready = load_ready_q;
  assign load_busy  = load_busy_q;
  assign load_err   = load_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= RESET_IMAGE[i];
    end else if (wr_en) begin
      mem_q[wptr_q] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      wptr_q       <= 4'd0;
      idle_q       <= 24'd0;
      cpu_run_q    <= 1'b0;
      load_ready_q <= 1'b0;
      load_busy_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          cpu_run_q <= 1'b1;
          if (load_start) begin
            state_q      <= LOAD;
            wptr_q       <= 4'd0;
            idle_q       <= 24'd0;
            load_err_q   <= 1'b0;
            cpu_run_q    <= 1'b0;
            load_ready_q <= 1'b1;
            load_busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            wptr_q <= 4'd0;
            idle_q <= 24'd0;
          end else if (wr_en) begin
            wptr_q <= wptr_q + 4'd1;
            idle_q <= 24'd0;
            if (wptr_q == 4'd15) begin
              state_q      <= RUN;
              cpu_run_q    <= 1'b1;
              load_ready_q <= 1'b0;
              load_busy_q  <= 1'b0;
            end
          end else if (idle_q == TIMEOUT - 24'd1) begin
            state_q      <= RUN;
            wptr_q       <= 4'd0;
            idle_q       <= 24'd0;
            load_err_q   <= 1'b1;
            cpu_run_q    <= 1'b1;
            load_ready_q <= 1'b0;
            load_busy_q  <= 1'b0;
          end else begin
            idle_q <= idle_d;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: reset image table, full load, timeout, restart, reset mid-load.
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] adr;
  logic [7:0] dout;
  logic       load_start, load_valid;
  logic [7:0] load_data;
  logic       load_ready, cpu_run, load_err, load_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } sb_t;

  sb_t        sbq[$];
  sb_t        vt[16];
  logic [7:0] mdl[16];

  prog_mem_loader #(.TIMEOUT(24'd8)) dut (
    .clk(clk), .reset(reset), .adr(adr), .dout(dout),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .cpu_run(cpu_run), .load_err(load_err), .load_busy(load_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] img(input int k);
`ifdef PMEM_DEFAULT_PROG_EN
    case (k)
      0: return 8'hA1;
      1: return 8'h30;
      2: return 8'h78;
      3: return 8'h91;
      default: return 8'h00;
    endcase
`else
    if (k < 0) return 8'hFF;
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_status(input string nm, input logic r, input logic rd, input logic bz, input logic er);
    check8({nm, "_cpu_run"}, {7'd0, cpu_run}, {7'd0, r});
    check8({nm, "_ready"}, {7'd0, load_ready}, {7'd0, rd});
    check8({nm, "_busy"}, {7'd0, load_busy}, {7'd0, bz});
    check8({nm, "_err"}, {7'd0, load_err}, {7'd0, er});
  endtask

  task automatic send_byte(input logic [3:0] a, input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    sbq.push_back('{a, d});
    mdl[a] = d;
    $display("load byte adr=%0d data=%h", a, d);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      adr = e.a;
      #1;
      check8(nm, dout, e.d);
      $display("read %s adr=%0d dout=%h", nm, e.a, dout);
    end
  endtask

  task automatic push_all();
    for (int k = 0; k < 16; k++) sbq.push_back('{4'(k), mdl[k]});
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16; k++) begin
      vt[k]  = '{4'(k), img(k)};
      mdl[k] = img(k);
    end
    reset = 1'b1; adr = 4'd0; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;

    // Reset image, table-driven, swept while reset is held
    tick();
    check_status("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      adr = vt[k].a;
      #1;
      check8("reset_image", dout, vt[k].d);
    end
    tick();
    reset = 1'b0;
    #1;
    check8("cpu_run_before_edge", {7'd0, cpu_run}, 8'd0);
    tick();
    check_status("after_release", 1'b1, 1'b0, 1'b0, 1'b0);

    // Full 16-byte back-to-back load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_status("load_entry", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      send_byte(4'(k), 8'h10 + 8'(k));
      if (k < 15) check8("cpu_run_during_load", {7'd0, cpu_run}, 8'd0);
    end
    check_status("load_done", 1'b1, 1'b0, 1'b0, 1'b0);
    drain("full_load");

    // Bytes offered in RUN are ignored
    load_valid = 1'b1; load_data = 8'hFF;
    tick(); tick();
    load_valid = 1'b0;
    check_status("run_ignore", 1'b1, 1'b0, 1'b0, 1'b0);
    push_all();
    drain("run_ignore_mem");

    // Timeout after 3 bytes
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 3; k++) send_byte(4'(k), 8'hC0 + 8'(k));
    n = 0;
    while (load_busy && n < 50) begin
      tick();
      n++;
    end
    check8("timeout_cycles", 8'(n), 8'd8);
    check_status("timeout", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 3; k < 16; k++) sbq.push_back('{4'(k), mdl[k]});
    drain("timeout_mem");
    tick();
    check8("err_sticky", {7'd0, load_err}, 8'd1);

    // Restart with a simultaneous byte on the 5th slot
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_status("reload_entry", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(4'(k), 8'hA0 + 8'(k));
    sbq.delete();
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
    $display("restart with discarded byte data=%h", load_data);
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    check_status("restart", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) send_byte(4'(k), 8'h50 + 8'(k));
    check_status("restart_done", 1'b1, 1'b0, 1'b0, 1'b0);
    drain("restart_mem");

    // Reset during load after 7 bytes
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 7; k++) send_byte(4'(k), 8'h70 + 8'(k));
    sbq.delete();
    reset = 1'b1;
    #1;
    check_status("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) mdl[k] = img(k);
    push_all();
    drain("mid_reset_mem");
    tick();
    reset = 1'b0;
    tick();
    check_status("mid_reset_release", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
